// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the gesture CNN accelerator: issues one-cycle start pulses to
// each enabled layer engine in order, waits for its done, and faults on a watchdog timeout.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 32,
  localparam int LW            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_mask,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LW-1:0]         err_layer,
  output logic [LW-1:0]         cur_layer,
  output logic [CNT_WIDTH-1:0]  total_cycles
);

  localparam int      WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, RUN, FINISH, FAULT} state_t;

  state_t                state, state_d;
  logic [LW-1:0]         cur_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d, ls_d;
  logic [WD_W-1:0]       wd;
  logic                  wd_expired, start_acc, cur_done;

  assign start_acc  = (state == IDLE) && start;
  assign cur_done   = layer_done[cur_layer];
  // A timeout of zero disables the watchdog entirely.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);
  assign error = (state == FAULT);

  always_comb begin
    state_d = state;
    cur_d   = cur_layer;
    mask_d  = mask_q;
    ls_d    = '0;
    unique case (state)
      IDLE: if (start) begin
        state_d = ISSUE;
        cur_d   = '0;
        mask_d  = layer_mask;
      end
      ISSUE: begin
        if (mask_q[cur_layer])       state_d = RUN;
        else if (cur_layer == LAST)  state_d = FINISH;
        else                         cur_d   = cur_layer + LW'(1);
      end
      RUN: begin
        if (cur_done) begin
          if (cur_layer == LAST) state_d = FINISH;
          else begin
            state_d = ISSUE;
            cur_d   = cur_layer + LW'(1);
          end
        end else if (wd_expired) begin
          state_d = FAULT;
        end
      end
      FINISH:  state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) state_d = IDLE;
    // Start pulse is registered: computed for the ISSUE cycle we are about to enter.
    if (state_d == ISSUE && mask_d[cur_d]) ls_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_layer    <= '0;
      mask_q       <= '0;
      layer_start  <= '0;
      wd           <= '0;
      err_layer    <= '0;
      total_cycles <= '0;
    end else begin
      state       <= state_d;
      cur_layer   <= cur_d;
      mask_q      <= mask_d;
      layer_start <= ls_d;

      if (state == ISSUE)                wd <= '0;
      else if (state == RUN && !cur_done) wd <= wd + WD_W'(1);

      if (start_acc)                               err_layer <= '0;
      else if (state == RUN && state_d == FAULT)   err_layer <= cur_layer;

      if (start_acc)
        total_cycles <= '0;
      else if (state != IDLE && total_cycles != '1)
        total_cycles <= total_cycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level scheduler for the gesture CNN accelerator. It starts each layer engine (depthwise conv, pointwise conv, pooling, dense) in a fixed order with a one-cycle start pulse and waits for that engine's done pulse. It skips layers disabled in a per-run mask and guards each layer with a watchdog timeout. It sits between the host/control interface and the layer engines, and it alone owns the engines' start/done handshakes.

## Interface
- NUM_LAYERS, 4, number of sequenced layer engines; index 0 runs first.
- TIMEOUT_CYCLES, 65535, maximum RUN cycles allowed per layer; 0 disables the watchdog.
- CNT_WIDTH, 32, width of the total cycle counter.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- abort  in  1  cancels a run or clears a fault; any non-IDLE state returns to IDLE.
- layer_mask  in  NUM_LAYERS  bit i=1 runs layer i; sampled on the start-accept cycle only.
- layer_done  in  NUM_LAYERS  per-engine done pulses.
- layer_start  out  NUM_LAYERS  one-hot start pulse, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  high while in FAULT.
- err_layer  out  $clog2(NUM_LAYERS)  index of the layer that timed out; held until next accepted start.
- cur_layer  out  $clog2(NUM_LAYERS)  layer index currently issued or running.
- total_cycles  out  CNT_WIDTH  busy cycles of the last or current run; saturates at all-ones; held after done, fault or abort until the next start.

## Operation
- States: IDLE, ISSUE, RUN, FINISH, FAULT.
- IDLE: when start=1, latch layer_mask, set cur_layer=0, clear total_cycles and err_layer, go to ISSUE.
- ISSUE (one cycle per layer):
  - If mask[cur_layer]=1, drive layer_start[cur_layer]=1, clear the watchdog, go to RUN.
  - If mask[cur_layer]=0, drive no pulse. If cur_layer is the last layer, go to FINISH; otherwise increment cur_layer and stay in ISSUE.
- RUN:
  - Only layer_done[cur_layer] is observed. Done bits of other layers, and any done seen in ISSUE or IDLE, are ignored.
  - On done: if cur_layer is the last layer, go to FINISH; otherwise increment cur_layer and go to ISSUE.
  - Watchdog: increments every RUN cycle without done. If the count equals TIMEOUT_CYCLES-1 and no done is present, go to FAULT and set err_layer=cur_layer.
- FINISH: done=1 for this one cycle, then go to IDLE.
- FAULT: error=1 and busy=1. start is ignored; only abort exits, to IDLE.
- Priorities:
  - abort beats done and timeout.
  - done beats timeout in the same cycle.
  - start while busy is ignored.
  - abort in IDLE has no effect.
- total_cycles increments (saturating) every cycle busy=1, including FINISH and FAULT cycles.

## Timing
- Reset values: all outputs 0, state IDLE, cur_layer 0, watchdog 0.
- start accepted in cycle T gives ISSUE in T+1, with layer_start valid in T+1.
- First RUN cycle is T+2.
- layer_done in cycle D gives the next ISSUE, or FINISH, in D+1. Per enabled layer, overhead is 1 ISSUE cycle plus engine latency.
- Each masked layer costs exactly 1 cycle.
- busy deasserts the cycle after FINISH.
- A new start can be accepted the cycle after FINISH, since the FSM is back in IDLE.
- Reset mid-run returns to IDLE immediately. No pending pulse survives reset.

## Test plan
- NUM_LAYERS=4, TIMEOUT_CYCLES=16, mask=4'b1111, start at cycle 0, each engine pulses done 3 cycles after its start:
  - layer_start pulses at cycles 1, 5, 9, 13.
  - done pulses at cycle 17, busy falls at 18.
  - total_cycles=17.
- mask=4'b0101, same engine latency:
  - pulses on layer 0 at cycle 1 and on layer 2 at cycle 6; no pulses on layers 1 or 3.
  - done at cycle 11, total_cycles=11.
- mask=4'b0000:
  - no layer_start pulses; done at cycle 5, total_cycles=5.
- Timeout: mask=4'b1111, layer 1 never answers (pulsed at cycle 5):
  - error rises at cycle 22 (RUN cycles 6..21), err_layer=1, done never asserts.
  - start at cycle 30 is ignored; abort at cycle 30 gives busy=0 and error=0 at cycle 31.
- Priorities:
  - abort concurrent with layer_done[2] in RUN: IDLE next cycle, no done, no layer_start[3].
  - layer_done[3] asserted while layer 1 runs: no effect.
  - done and watchdog expiry in the same cycle: the run proceeds and error stays 0.
- Reset mid-run: rst asserted during layer 2 RUN gives all outputs 0 at once; a new start after release restarts from layer 0.
